branch_predictor: RTL and testbench

Parametrised branch target buffer with saturating-counter direction prediction for the 5-stage MIPS pipeline. Sits beside the IF-stage PC register: it predicts next-fetch PC combinationally from the current PC and is trained from EX when a branch or jump resolves. It supplies a speculative target the pipeline has no other source for. It also keeps a running mispredict count for performance debug.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/sat_counter.sv | 19 +
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: machine word and BTB entry layout.
// btb_entry_t fixes field order at the widest legal geometry; modules narrow it locally.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int BTB_TAG_MAX = 29;
  localparam int BTB_CNT_MAX = 4;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    word_t                  target;
    logic [BTB_CNT_MAX-1:0] cnt;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - combinational next value of a W-bit saturating up/down counter.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] next
);

  always_comb begin
    next = cnt;
    if (inc && (cnt != {W{1'b1}}))
      next = cnt + W'(1);
    else if (dec && (cnt != '0))
      next = cnt - W'(1);
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB with saturating direction counters and mispredict counter.
// Lookup is combinational from pc; training from EX takes effect on the next edge.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        en,
  input  logic        flush,
  input  word_t       pc,
  output logic        pred_taken,
  output word_t       pred_target,
  input  logic        update_en,
  input  word_t       update_pc,
  input  logic        update_taken,
  input  word_t       update_target,
  input  logic        update_mispred,
  output word_t       mispred_count
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam logic [CNT_BITS-1:0] WT = CNT_BITS'(1 << (CNT_BITS - 1));

  // Same field order as cpu_types_pkg::btb_entry_t, narrowed to this geometry.
  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    word_t               target;
    logic [CNT_BITS-1:0] cnt;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  entry_t              lk_ent, up_ent;
  logic                lk_hit, up_hit;
  logic [CNT_BITS-1:0] cnt_next;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{pc[1:0], update_pc[1:0]};

  assign lk_idx = pc[IDX_BITS+1:2];
  assign lk_tag = pc[31:IDX_BITS+2];
  assign lk_ent = tbl[lk_idx];
  assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

  assign pred_taken  = lk_hit && lk_ent.cnt[CNT_BITS-1];
  assign pred_target = pred_taken ? lk_ent.target : pc + 32'd4;

  assign up_idx = update_pc[IDX_BITS+1:2];
  assign up_tag = update_pc[31:IDX_BITS+2];
  assign up_ent = tbl[up_idx];
  assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

  sat_counter #(.W(CNT_BITS)) u_cnt (
    .cnt  (up_ent.cnt),
    .inc  (update_taken),
    .dec  (!update_taken),
    .next (cnt_next)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid  <= 1'b0;
        tbl[i].tag    <= '0;
        tbl[i].target <= '0;
        tbl[i].cnt    <= WT - CNT_BITS'(1);
      end
    end else if (en) begin
      // flush wins over a same-cycle update; counters and targets survive it.
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++)
          tbl[i].valid <= 1'b0;
      end else if (update_en) begin
        if (up_hit) begin
          tbl[up_idx].cnt <= cnt_next;
          if (update_taken)
            tbl[up_idx].target <= update_target;
        end else if (update_taken) begin
          tbl[up_idx].valid  <= 1'b1;
          tbl[up_idx].tag    <= up_tag;
          tbl[up_idx].target <= update_target;
          tbl[up_idx].cnt    <= WT;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      mispred_count <= '0;
    else if (en && update_en && update_mispred && (mispred_count != 32'hFFFF_FFFF))
      mispred_count <= mispred_count + 32'd1;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor.
module tb_branch_predictor;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  en, flush;
  word_t pc;
  logic  pred_taken;
  word_t pred_target;
  logic  update_en, update_taken, update_mispred;
  word_t update_pc, update_target;
  word_t mispred_count;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  branch_predictor #(.ENTRIES(16), .CNT_BITS(2)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .en             (en),
    .flush          (flush),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .update_en      (update_en),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target),
    .update_mispred (update_mispred),
    .mispred_count  (mispred_count)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input word_t a, input logic tk, input word_t tgt, input logic mp);
    update_en = 1'b1; update_pc = a; update_taken = tk; update_target = tgt; update_mispred = mp;
    tick();
    update_en = 1'b0; update_mispred = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; en = 1'b1; flush = 1'b0; pc = 32'h40;
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0; update_mispred = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    #1;
    total++; if (pred_taken !== 1'b0) $display("FAIL reset_taken got %0b want 0", pred_taken); else passed++;
    total++; if (pred_target !== 32'h44) $display("FAIL reset_target got %h want 00000044", pred_target); else passed++;
    total++; if (mispred_count !== 32'd0) $display("FAIL reset_mispred got %0d want 0", mispred_count); else passed++;
  endtask

  task automatic test_allocate();
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    pc = 32'h40; #1;
    total++; if (pred_taken !== 1'b1) $display("FAIL alloc_taken got %0b want 1", pred_taken); else passed++;
    total++; if (pred_target !== 32'h100) $display("FAIL alloc_target got %h want 00000100", pred_target); else passed++;
    total++; if (dut.tbl[0].cnt !== 2'b10) $display("FAIL alloc_cnt got %b want 10", dut.tbl[0].cnt); else passed++;
    pc = 32'h440; #1;
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'h444)
      $display("FAIL alias_miss got %0b/%h want 0/00000444", pred_taken, pred_target); else passed++;
  endtask

  task automatic test_saturate();
    pc = 32'h40;
    for (int i = 0; i < 3; i++) upd(32'h40, 1'b1, 32'h100, 1'b0);
    total++; if (dut.tbl[0].cnt !== 2'b11) $display("FAIL sat_hi got %b want 11", dut.tbl[0].cnt); else passed++;
    for (int i = 0; i < 2; i++) upd(32'h40, 1'b0, 32'h0, 1'b0);
    total++; if (dut.tbl[0].cnt !== 2'b01) $display("FAIL dec2_cnt got %b want 01", dut.tbl[0].cnt); else passed++;
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'h44)
      $display("FAIL dec2_pred got %0b/%h want 0/00000044", pred_taken, pred_target); else passed++;
    total++; if (dut.tbl[0].valid !== 1'b1) $display("FAIL dec2_valid got %0b want 1", dut.tbl[0].valid); else passed++;
    for (int i = 0; i < 2; i++) upd(32'h40, 1'b0, 32'h0, 1'b0);
    total++; if (dut.tbl[0].cnt !== 2'b00) $display("FAIL sat_lo got %b want 00", dut.tbl[0].cnt); else passed++;
  endtask

  task automatic test_same_cycle();
    flush = 1'b1; tick(); flush = 1'b0;
    pc = 32'h40;
    update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_target = 32'h100;
    #1;
    total++; if (pred_taken !== 1'b0) $display("FAIL same_cycle_pre got %0b want 0", pred_taken); else passed++;
    tick(); update_en = 1'b0;
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h100)
      $display("FAIL same_cycle_post got %0b/%h want 1/00000100", pred_taken, pred_target); else passed++;
    en = 1'b0;
    upd(32'h40, 1'b1, 32'h200, 1'b1);
    en = 1'b1;
    total++; if (pred_target !== 32'h100 || dut.tbl[0].cnt !== 2'b10)
      $display("FAIL en_freeze got %h/%b want 00000100/10", pred_target, dut.tbl[0].cnt); else passed++;
    total++; if (mispred_count !== 32'd0) $display("FAIL en_freeze_mp got %0d want 0", mispred_count); else passed++;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    upd(32'h80, 1'b1, 32'h300, 1'b1);
    flush = 1'b0;
    pc = 32'h40; #1;
    total++; if (pred_taken !== 1'b0) $display("FAIL flush_40 got %0b want 0", pred_taken); else passed++;
    pc = 32'h80; #1;
    total++; if (pred_taken !== 1'b0 || dut.tbl[0].valid !== 1'b0)
      $display("FAIL flush_80 got %0b/%0b want 0/0", pred_taken, dut.tbl[0].valid); else passed++;
    total++; if (mispred_count !== 32'd1) $display("FAIL flush_mp got %0d want 1", mispred_count); else passed++;
    pc = 32'hFFFF_FFFC; #1;
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'h0)
      $display("FAIL wrap got %0b/%h want 0/00000000", pred_taken, pred_target); else passed++;
  endtask

  task automatic test_mispred_reset();
    for (int i = 0; i < 4; i++) upd(32'h10, 1'b0, 32'h0, 1'b1);
    total++; if (mispred_count !== 32'd5) $display("FAIL mispred_5 got %0d want 5", mispred_count); else passed++;
    upd(32'h40, 1'b1, 32'h120, 1'b0);
    pc = 32'h40; #1;
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h120)
      $display("FAIL realloc got %0b/%h want 1/00000120", pred_taken, pred_target); else passed++;
    #2 nRST = 1'b0;
    #1;
    total++; if (mispred_count !== 32'd0) $display("FAIL async_mp got %0d want 0", mispred_count); else passed++;
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'h44)
      $display("FAIL async_lookup got %0b/%h want 0/00000044", pred_taken, pred_target); else passed++;
    upd(32'h80, 1'b1, 32'h300, 1'b1);
    nRST = 1'b1;
    pc = 32'h80; #1;
    total++; if (pred_taken !== 1'b0 || mispred_count !== 32'd0)
      $display("FAIL reset_discard got %0b/%0d want 0/0", pred_taken, mispred_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturate();
    test_same_cycle();
    test_flush();
    test_mispred_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
